can_error_frame_gen: RTL and testbench

CAN_ERROR_FRAME_GEN -- requirements
Module: can_error_frame_gen

---
 rtl/can_error_frame_gen_if.sv | 34 +++
 rtl/can_error_frame_gen.sv | 148 ++++++++++++++
 tb/tb_can_error_frame_gen.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/can_error_frame_gen_if.sv
// Signal bundle between the CAN bit-timing/error-detection logic and the
// error frame generator.
interface can_error_frame_gen_if;
    logic sample_point;
    logic rx_bit;
    logic bit_error;
    logic stuff_error;
    logic crc_error;
    logic form_error;
    logic ack_error;
    logic error_passive;
    logic bus_off;
    logic tx_bit;
    logic err_frame_busy;
    logic sending_error_flag_passive;
    logic in_error_delim;
    logic dom_overrun;
    logic delim_form_error;
    logic frame_done;

    modport master (
        output sample_point, rx_bit, bit_error, stuff_error, crc_error,
               form_error, ack_error, error_passive, bus_off,
        input  tx_bit, err_frame_busy, sending_error_flag_passive,
               in_error_delim, dom_overrun, delim_form_error, frame_done
    );

    modport slave (
        input  sample_point, rx_bit, bit_error, stuff_error, crc_error,
               form_error, ack_error, error_passive, bus_off,
        output tx_bit, err_frame_busy, sending_error_flag_passive,
               in_error_delim, dom_overrun, delim_form_error, frame_done
    );
endinterface

// File: rtl/can_error_frame_gen.sv
// CAN error frame generator: active/passive error flag, superposition
// overrun tracking and error delimiter, all counted in sample points.
module can_error_frame_gen (
    input  logic            clk,
    input  logic            rst,
    can_error_frame_gen_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ACT_FLAG, PAS_FLAG, WAIT_REC, DELIM} state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       prev_rx, prev_rx_nxt;
    logic [3:0] run;
    logic       any_err;
    logic       ovr_nxt, dfe_nxt, done_nxt;
    logic       tx_nxt, busy_nxt, pas_nxt, delim_nxt;
    logic       tx_q, busy_q, pas_q, delim_q, ovr_q, dfe_q, done_q;

    assign any_err = bus.bit_error | bus.stuff_error | bus.crc_error |
                     bus.form_error | bus.ack_error;

    // Equal-run length in the passive flag; cnt==0 marks the first sample.
    assign run = (cnt == 4'd0) ? 4'd1 :
                 (bus.rx_bit == prev_rx) ? cnt + 4'd1 : 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            prev_rx <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            pas_q   <= 1'b0;
            delim_q <= 1'b0;
            ovr_q   <= 1'b0;
            dfe_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            prev_rx <= prev_rx_nxt;
            tx_q    <= tx_nxt;
            busy_q  <= busy_nxt;
            pas_q   <= pas_nxt;
            delim_q <= delim_nxt;
            ovr_q   <= ovr_nxt;
            dfe_q   <= dfe_nxt;
            done_q  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        prev_rx_nxt = prev_rx;
        ovr_nxt     = 1'b0;
        dfe_nxt     = 1'b0;
        done_nxt    = 1'b0;
        case (state)
            IDLE: begin
                // done_q blocks a strobe that lands on the frame_done cycle.
                if (any_err && !bus.bus_off && !done_q) begin
                    state_nxt   = bus.error_passive ? PAS_FLAG : ACT_FLAG;
                    cnt_nxt     = 4'd0;
                    prev_rx_nxt = 1'b0;
                end
            end
            ACT_FLAG: begin
                if (bus.sample_point) begin
                    if (cnt == 4'd5) begin
                        state_nxt = WAIT_REC;
                        cnt_nxt   = 4'd6;
                    end else begin
                        cnt_nxt = cnt + 4'd1;
                    end
                end
            end
            PAS_FLAG: begin
                if (bus.sample_point) begin
                    prev_rx_nxt = bus.rx_bit;
                    if (run == 4'd6) begin
                        state_nxt = WAIT_REC;
                        cnt_nxt   = 4'd6;
                    end else begin
                        cnt_nxt = run;
                    end
                end
            end
            WAIT_REC: begin
                if (bus.sample_point) begin
                    if (bus.rx_bit) begin
                        state_nxt = DELIM;
                        cnt_nxt   = 4'd1;
                    end else if (cnt == 4'd13) begin
                        ovr_nxt = 1'b1;
                        cnt_nxt = 4'd6;
                    end else begin
                        cnt_nxt = cnt + 4'd1;
                    end
                end
            end
            DELIM: begin
                if (bus.sample_point) begin
                    if (!bus.rx_bit) begin
                        dfe_nxt     = 1'b1;
                        state_nxt   = bus.error_passive ? PAS_FLAG : ACT_FLAG;
                        cnt_nxt     = 4'd0;
                        prev_rx_nxt = 1'b0;
                    end else if (cnt == 4'd7) begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                        cnt_nxt   = 4'd0;
                    end else begin
                        cnt_nxt = cnt + 4'd1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
        // Bus-off overrides any in-progress frame and suppresses its pulses.
        if (state != IDLE && bus.bus_off) begin
            state_nxt   = IDLE;
            cnt_nxt     = 4'd0;
            prev_rx_nxt = 1'b0;
            ovr_nxt     = 1'b0;
            dfe_nxt     = 1'b0;
            done_nxt    = 1'b0;
        end
    end

    always_comb begin
        tx_nxt    = (state_nxt != ACT_FLAG);
        busy_nxt  = (state_nxt != IDLE);
        pas_nxt   = (state_nxt == PAS_FLAG);
        delim_nxt = (state_nxt == DELIM);
    end

    assign bus.tx_bit                     = tx_q;
    assign bus.err_frame_busy             = busy_q;
    assign bus.sending_error_flag_passive = pas_q;
    assign bus.in_error_delim             = delim_q;
    assign bus.dom_overrun                = ovr_q;
    assign bus.delim_form_error           = dfe_q;
    assign bus.frame_done                 = done_q;
endmodule

// File: tb/tb_can_error_frame_gen.sv
// Directed bench for can_error_frame_gen; outputs are checked as the packed
// vector {tx, busy, passive, delim, overrun, delim_form_err, done}.
module tb_can_error_frame_gen;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    can_error_frame_gen_if bus ();

    can_error_frame_gen dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] outs();
        return {bus.tx_bit, bus.err_frame_busy, bus.sending_error_flag_passive,
                bus.in_error_delim, bus.dom_overrun, bus.delim_form_error,
                bus.frame_done};
    endfunction

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One sample point, followed by a gap cycle; returns just after the
    // edge that consumed the sample.
    task automatic bit_time(input logic rx);
        @(negedge clk);
        bus.sample_point = 1'b1;
        bus.rx_bit       = rx;
        @(negedge clk);
        bus.sample_point = 1'b0;
    endtask

    task automatic strobe_bit_error(input logic passive);
        @(negedge clk);
        bus.bit_error     = 1'b1;
        bus.error_passive = passive;
        @(negedge clk);
        bus.bit_error     = 1'b0;
    endtask

    localparam logic [6:0] O_IDLE  = 7'b1000000;
    localparam logic [6:0] O_ACT   = 7'b0100000;
    localparam logic [6:0] O_PAS   = 7'b1110000;
    localparam logic [6:0] O_WAIT  = 7'b1100000;
    localparam logic [6:0] O_DELIM = 7'b1101000;
    localparam logic [6:0] O_DONE  = 7'b1000001;
    localparam logic [6:0] O_OVR   = 7'b1100100;
    localparam logic [6:0] O_DFE   = 7'b0100010;

    initial begin
        logic [0:7] pas_seq;
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.sample_point  = 1'b0;
        bus.rx_bit        = 1'b1;
        bus.bit_error     = 1'b0;
        bus.stuff_error   = 1'b0;
        bus.crc_error     = 1'b0;
        bus.form_error    = 1'b0;
        bus.ack_error     = 1'b0;
        bus.error_passive = 1'b0;
        bus.bus_off       = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", outs(), O_IDLE);
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_reset", outs(), O_IDLE);

        // Bus-off in IDLE ignores strobes.
        bus.bus_off = 1'b1;
        strobe_bit_error(1'b0);
        @(negedge clk);
        check("busoff_idle_ignores", outs(), O_IDLE);
        bus.bus_off = 1'b0;

        // Active frame on a recessive bus.
        strobe_bit_error(1'b0);
        check("act_entry", outs(), O_ACT);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) bus.crc_error = 1'b1;
            bit_time(1'b0);
            bus.crc_error = 1'b0;
            check($sformatf("act_flag_bit%0d", i + 1), outs(), O_ACT);
        end
        repeat (3) @(negedge clk);
        check("act_no_count_without_sp", outs(), O_ACT);
        bit_time(1'b0);
        check("act_flag_end", outs(), O_WAIT);
        bit_time(1'b1);
        check("act_delim_entry", outs(), O_DELIM);
        for (int i = 0; i < 6; i++) begin
            bit_time(1'b1);
            check($sformatf("act_delim_s%0d", i + 2), outs(), O_DELIM);
        end
        bit_time(1'b1);
        check("act_frame_done_at_14", outs(), O_DONE);
        bus.bit_error = 1'b1;
        @(negedge clk);
        bus.bit_error = 1'b0;
        check("strobe_on_done_ignored", outs(), O_IDLE);
        @(negedge clk);
        check("still_idle_after_done", outs(), O_IDLE);

        // Passive flag with a dominant run starting mid-flag.
        @(negedge clk);
        bus.stuff_error   = 1'b1;
        bus.error_passive = 1'b1;
        @(negedge clk);
        bus.stuff_error   = 1'b0;
        bus.error_passive = 1'b0;
        check("pas_entry", outs(), O_PAS);
        pas_seq = 8'b11000000;
        for (int i = 0; i < 7; i++) begin
            bit_time(pas_seq[i]);
            check($sformatf("pas_sample%0d", i + 1), outs(), O_PAS);
        end
        bit_time(pas_seq[7]);
        check("pas_leave_at_8th", outs(), O_WAIT);
        bit_time(1'b1);
        check("pas_delim_entry", outs(), O_DELIM);
        for (int i = 0; i < 6; i++) bit_time(1'b1);
        bit_time(1'b1);
        check("pas_frame_done", outs(), O_DONE);

        // Superposition: 16 extra dominant bits after an active flag.
        @(negedge clk);
        strobe_bit_error(1'b0);
        for (int i = 0; i < 6; i++) bit_time(1'b0);
        check("sup_wait_entry", outs(), O_WAIT);
        for (int i = 0; i < 16; i++) begin
            bit_time(1'b0);
            check($sformatf("sup_dom%0d", i + 1), outs(),
                  (i == 7 || i == 15) ? O_OVR : O_WAIT);
        end
        bit_time(1'b1);
        check("sup_delim_entry", outs(), O_DELIM);

        // Delimiter fault at the 4th delimiter sample restarts an active flag.
        bit_time(1'b1);
        bit_time(1'b1);
        check("dfe_before", outs(), O_DELIM);
        bit_time(1'b0);
        check("dfe_pulse_act", outs(), O_DFE);
        @(negedge clk);
        check("dfe_pulse_clears", outs(), O_ACT);

        // Bus-off during the 3rd flag bit aborts without frame_done.
        bit_time(1'b0);
        bit_time(1'b0);
        @(negedge clk);
        bus.sample_point = 1'b1;
        bus.rx_bit       = 1'b0;
        bus.bus_off      = 1'b1;
        @(negedge clk);
        bus.sample_point = 1'b0;
        bus.bus_off      = 1'b0;
        check("busoff_abort", outs(), O_IDLE);
        for (int i = 0; i < 4; i++) bit_time(1'b1);
        check("busoff_no_done", outs(), O_IDLE);

        // Reset during the delimiter.
        strobe_bit_error(1'b0);
        for (int i = 0; i < 6; i++) bit_time(1'b0);
        for (int i = 0; i < 3; i++) bit_time(1'b1);
        check("rst_pre_delim", outs(), O_DELIM);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_delim", outs(), O_IDLE);
        rst = 1'b0;
        @(negedge clk);
        check("rst_released_idle", outs(), O_IDLE);

        // Fresh frame after reset: counters start from zero.
        strobe_bit_error(1'b0);
        for (int i = 0; i < 5; i++) bit_time(1'b0);
        check("post_rst_flag5", outs(), O_ACT);
        bit_time(1'b0);
        check("post_rst_flag6", outs(), O_WAIT);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
